lfsr_burst_arbiter: RTL and testbench

Controller that owns one Fibonacci LFSR and shares its pseudo-random output among NREQ requesters. Each granted requester receives one burst of consecutive LFSR words. Grants rotate round-robin. The block also handles seed loading, guards against the all-zero lock-up state, and flags when the sequence period wraps. It sits between the LFSR datapath and the blocks that consume random words (scramblers, test pattern sources).

---
 rtl/lfsr_burst_arbiter.sv | 133 +++++++++++++
 tb/tb_lfsr_burst_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that hands out bursts of consecutive words from one shared Fibonacci LFSR.
// Also loads seeds (a zero seed is replaced by SEED_INIT) and pulses wrap when the sequence returns to its start.
module lfsr_burst_arbiter #(
    parameter int           n         = 8,
    parameter logic [n-1:0] TAPS      = 8'hB8,
    parameter logic [n-1:0] SEED_INIT = 8'h01,
    parameter int           NREQ      = 4,
    parameter int           LEN_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic                  seed_valid,
    input  logic [n-1:0]          seed,
    output logic                  seed_ready,
    output logic [NREQ-1:0]       gnt,
    output logic                  data_valid,
    output logic [n-1:0]          data,
    output logic                  data_last,
    output logic                  busy,
    output logic                  wrap
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [n-1:0]     r_s, w_s_nxt;
    logic [n-1:0]     r_ref, w_ref_nxt;
    logic             r_stepped, w_stepped_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0] r_win, w_win_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;

    logic             w_fb;
    logic [n-1:0]     w_step;
    logic [n-1:0]     w_seed_eff;
    logic             w_found;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W-1:0] w_idx;
    logic [LEN_W-1:0] w_len [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
        assign w_len[gi] = req_len[gi*LEN_W +: LEN_W];
    end

    assign w_fb       = ^(r_s & TAPS);
    assign w_step     = {r_s[n-2:0], w_fb};
    assign w_seed_eff = (seed == '0) ? SEED_INIT : seed;

    // Round-robin search begins one past the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_s_nxt       = r_s;
        w_ref_nxt     = r_ref;
        w_stepped_nxt = r_stepped;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (seed_valid) begin
                    w_s_nxt       = w_seed_eff;
                    w_ref_nxt     = w_seed_eff;
                    w_stepped_nxt = 1'b0;
                end else if (w_found) begin
                    w_cnt_nxt   = w_len[w_win];
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_win_nxt   = w_win;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_s_nxt       = w_step;
                w_stepped_nxt = 1'b1;
                w_cnt_nxt     = r_cnt - LEN_W'(1);
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = r_win;
                    w_gnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_s       <= SEED_INIT;
            r_ref     <= SEED_INIT;
            r_stepped <= 1'b0;
            r_ptr     <= PTR_W'(NREQ - 1);
            r_win     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_ref     <= w_ref_nxt;
            r_stepped <= w_stepped_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
        end
    end

    assign busy       = (r_state == S_RUN);
    assign data_valid = busy;
    assign seed_ready = (r_state == S_IDLE);
    assign gnt        = r_gnt;
    assign data       = r_s;
    assign data_last  = busy && (r_cnt == '0);
    assign wrap       = busy && r_stepped && (r_s == r_ref);

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Scoreboard bench: the driver predicts each burst at transaction level and queues expected words;
// a negedge monitor pops and compares whenever the DUT presents a valid word.
module tb_lfsr_burst_arbiter;
    localparam int         N         = 8;
    localparam int         NREQ      = 4;
    localparam int         LEN_W     = 4;
    localparam logic [7:0] TAPS      = 8'hB8;
    localparam logic [7:0] SEED_INIT = 8'h01;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic                  seed_valid;
    logic [N-1:0]          seed;
    logic                  seed_ready;
    logic [NREQ-1:0]       gnt;
    logic                  data_valid;
    logic [N-1:0]          data;
    logic                  data_last;
    logic                  busy;
    logic                  wrap;

    always #5 clk = ~clk;

    lfsr_burst_arbiter #(
        .n(N), .TAPS(TAPS), .SEED_INIT(SEED_INIT), .NREQ(NREQ), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready),
        .gnt(gnt), .data_valid(data_valid), .data(data), .data_last(data_last),
        .busy(busy), .wrap(wrap)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic       last;
        logic       wr;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_vec  = 0;
    int         n_err  = 0;
    int         n_wrap = 0;
    logic [7:0] m_s;
    logic [7:0] m_ref;
    bit         m_stepped;
    int         m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int fb;
        fb = $countones(s & TAPS) % 2;
        return 8'((int'(s) * 2 + fb) % 256);
    endfunction

    task automatic model_reset();
        m_s       = SEED_INIT;
        m_ref     = SEED_INIT;
        m_stepped = 0;
        m_ptr     = NREQ - 1;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                if (wrap) n_wrap++;
                chk("seed_ready_in_run", seed_ready, 0);
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("gnt", gnt, mon_e.g);
                    chk("data", data, mon_e.d);
                    chk("data_last", data_last, mon_e.last);
                    chk("wrap", wrap, mon_e.wr);
                end
            end else begin
                chk("idle_gnt", gnt, 0);
                chk("idle_last", data_last, 0);
                chk("idle_wrap", wrap, 0);
                chk("idle_busy", busy, 0);
                chk("idle_seed_ready", seed_ready, 1);
            end
        end
    end

    // Called at an IDLE point (negedge+2); returns at the first IDLE point after the burst.
    task automatic run_burst(input int len, input bit chaos, input int rst_after);
        int cyc;
        bit done;
        cyc  = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            #2;
            if (c == 0) chk("grant_latency", busy, 1);
            if (busy) begin
                cyc++;
                if (rst_after == cyc) begin
                    reset      = 1;
                    req        = '0;
                    seed_valid = 0;
                    model_reset();
                    @(negedge clk);
                    chk("rst_data_valid", data_valid, 0);
                    chk("rst_gnt", gnt, 0);
                    chk("rst_data", data, SEED_INIT);
                    chk("rst_seed_ready", seed_ready, 1);
                    #2 reset = 0;
                    return;
                end
                if (chaos) begin
                    req        = req & 4'($urandom);
                    seed_valid = 1'($urandom_range(0, 1));
                    seed       = 8'($urandom);
                end
            end else begin
                done       = 1;
                seed_valid = 0;
            end
        end
        chk("burst_len", cyc, len + 1);
    endtask

    task automatic issue(input logic [3:0] mask, input logic [15:0] lens, input bit chaos, input int rst_after);
        int   w;
        int   idx;
        int   len;
        exp_t e;
        req        = mask;
        req_len    = lens;
        seed_valid = 0;
        if (mask == 0) begin
            @(negedge clk);
            #2;
            chk("no_req_stays_idle", busy, 0);
            return;
        end
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && ((mask >> idx) & 1) == 1) w = idx;
        end
        len = int'((lens >> (w * LEN_W)) & 16'hF);
        for (int i = 0; i <= len; i++) begin
            e.g    = 4'(1 << w);
            e.d    = m_s;
            e.last = (i == len);
            e.wr   = (m_s == m_ref) && m_stepped;
            sb.push_back(e);
            m_s       = lfsr_next(m_s);
            m_stepped = 1;
        end
        m_ptr = w;
        run_burst(len, chaos, rst_after);
    endtask

    task automatic load_seed(input logic [7:0] sd, input logic [3:0] mask);
        seed_valid = 1;
        seed       = sd;
        req        = mask;
        req_len    = 16'($urandom);
        m_s        = (sd == 0) ? SEED_INIT : sd;
        m_ref      = m_s;
        m_stepped  = 0;
        @(negedge clk);
        #2;
        seed_valid = 0;
        req        = '0;
        chk("seed_beats_req", busy, 0);
        chk("seed_loaded", data, m_s);
    endtask

    task automatic do_reset();
        reset      = 1;
        req        = '0;
        seed_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_data", data, SEED_INIT);
        chk("reset_gnt", gnt, 0);
        chk("reset_valid", data_valid, 0);
        chk("reset_seed_ready", seed_ready, 1);
        #2 reset = 0;
    endtask

    initial begin
        reset      = 1;
        req        = '0;
        req_len    = '0;
        seed_valid = 0;
        seed       = '0;
        do_reset();

        issue(4'b0001, 16'h0003, 0, 0);

        do_reset();
        for (int i = 0; i < 5; i++) issue(4'b1111, 16'h0000, 0, 0);

        load_seed(8'h00, 4'b1111);
        load_seed(8'h80, 4'b0010);
        issue(4'b0001, 16'h0002, 0, 0);

        issue(4'b0100, 16'h0500, 1, 0);

        do_reset();
        n_wrap = 0;
        for (int i = 0; i < 16; i++) issue(4'b0001, 16'h000F, 0, 0);
        chk("wrap_count_256", n_wrap, 1);

        do_reset();
        issue(4'b0001, 16'h000F, 0, 2);
        issue(4'b0001, 16'h0001, 0, 0);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 2)
                load_seed(8'($urandom), 4'($urandom));
            else
                issue(4'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
